// File: rtl/spy_pkg.sv
// rtl/spy_pkg.sv - shared state encoding and width helper for the SpyMangler guess entry
package spy_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_CHECK = 2'd1,
        ST_WIN   = 2'd2,
        ST_LOSE  = 2'd3
    } spy_state_t;

    // Bits needed to hold every value 0..n, never less than one.
    function automatic int width_of(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/button_press_classifier.sv
// rtl/button_press_classifier.sv - release detection and short/long hold classification
module button_press_classifier
    import spy_pkg::*;
#(
    parameter int LONG_PRESS = 3
) (
    input  logic clock,
    input  logic resetn,
    input  logic value_input,
    output logic release_pulse,
    output logic press_long
);

    localparam int HW = width_of(LONG_PRESS);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS);

    logic          r_prev_value;
    logic [HW-1:0] r_hold_cnt;

    // prev_value resets to released so the first edge after reset never looks like a release.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_prev_value <= 1'b1;
            r_hold_cnt   <= '0;
        end else begin
            r_prev_value <= value_input;
            if (value_input)
                r_hold_cnt <= '0;
            else if (r_hold_cnt < HOLD_MAX)
                r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    assign release_pulse = !r_prev_value && value_input;
    assign press_long    = (r_hold_cnt >= HOLD_MAX);

endmodule

// File: rtl/player_guess_entry.sv
// rtl/player_guess_entry.sv - player-2 code entry, submit/compare FSM and try counting
module player_guess_entry
    import spy_pkg::*;
#(
    parameter int CODE_WIDTH = 20,
    parameter int LONG_PRESS = 3,
    parameter int MAX_TRIES  = 3
) (
    input  logic                                 clock,
    input  logic                                 resetn,
    input  logic                                 value_input,
    input  logic                                 finish_input,
    input  logic [CODE_WIDTH-1:0]                player1_value,
    output logic [CODE_WIDTH-1:0]                q,
    output logic [width_of(CODE_WIDTH)-1:0]      bit_count,
    output logic [width_of(MAX_TRIES)-1:0]       tries_left,
    output logic                                 press_long,
    output logic                                 correct,
    output logic                                 game_over
);

    localparam int BCW = width_of(CODE_WIDTH);
    localparam int TW  = width_of(MAX_TRIES);
    localparam logic [BCW-1:0] BC_FULL    = BCW'(CODE_WIDTH);
    localparam logic [TW-1:0]  TRIES_INIT = TW'(MAX_TRIES);
    localparam logic [TW-1:0]  ONE_TRY    = TW'(1);

    spy_state_t            r_state;
    logic [CODE_WIDTH-1:0] r_q;
    logic [BCW-1:0]        r_bit_count;
    logic [TW-1:0]         r_tries_left;
    logic                  r_correct;
    logic                  r_game_over;
    logic                  r_prev_finish;

    logic w_release;
    logic w_press_long;
    logic w_push;
    logic w_submit;

    button_press_classifier #(
        .LONG_PRESS (LONG_PRESS)
    ) u_classifier (
        .clock         (clock),
        .resetn        (resetn),
        .value_input   (value_input),
        .release_pulse (w_release),
        .press_long    (w_press_long)
    );

    assign w_push = w_release && (r_state == ST_ENTRY) && (r_bit_count < BC_FULL);

    // A bit pushed on this same edge counts toward the non-empty guess requirement.
    assign w_submit = r_prev_finish && !finish_input && value_input &&
                      (r_state == ST_ENTRY) && ((r_bit_count != '0) || w_push);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_ENTRY;
            r_q           <= '0;
            r_bit_count   <= '0;
            r_tries_left  <= TRIES_INIT;
            r_correct     <= 1'b0;
            r_game_over   <= 1'b0;
            r_prev_finish <= 1'b1;
        end else begin
            r_prev_finish <= finish_input;
            case (r_state)
                ST_ENTRY: begin
                    if (w_push) begin
                        r_q         <= {r_q[CODE_WIDTH-2:0], w_press_long};
                        r_bit_count <= r_bit_count + 1'b1;
                    end
                    if (w_submit)
                        r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (r_q == player1_value) begin
                        r_state     <= ST_WIN;
                        r_correct   <= 1'b1;
                        r_game_over <= 1'b1;
                    end else if (r_tries_left > ONE_TRY) begin
                        r_tries_left <= r_tries_left - 1'b1;
                        r_q          <= '0;
                        r_bit_count  <= '0;
                        r_state      <= ST_ENTRY;
                    end else begin
                        r_tries_left <= '0;
                        r_game_over  <= 1'b1;
                        r_state      <= ST_LOSE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign q          = r_q;
    assign bit_count  = r_bit_count;
    assign tries_left = r_tries_left;
    assign press_long = w_press_long;
    assign correct    = r_correct;
    assign game_over  = r_game_over;

endmodule
